// File: rtl/eq_band_mac_scheduler.sv
// Equalizer gain stage: captures one band/gain set per sample and time-shares one multiplier
// across all bands. The summed band*gain is rounded and saturated to audio_out.
module eq_band_mac_scheduler #(
   parameter int NUM_BANDS = 10,
   parameter int DATA_W    = 24,
   parameter int GAIN_W    = 13,
   parameter int GAIN_FRAC = 9,
   localparam int ACC_W    = DATA_W + GAIN_W + $clog2(NUM_BANDS) + 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_BANDS*DATA_W-1:0] band_data,
   input  logic [NUM_BANDS*GAIN_W-1:0] gain_bus,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        busy,
   output logic [DATA_W-1:0]           audio_out,
   output logic                        out_valid,
   output logic [7:0]                  overrun_cnt
);
   localparam int IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
   localparam int PROD_W = DATA_W + GAIN_W + 1;
   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (GAIN_FRAC - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX  = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

   typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;

   state_t                        state_q, state_d;
   logic signed [ACC_W-1:0]       acc_q, acc_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic [NUM_BANDS*DATA_W-1:0]   band_sh_q, band_sh_d;
   logic [NUM_BANDS*GAIN_W-1:0]   gain_sh_q, gain_sh_d;
   logic [DATA_W-1:0]             audio_out_q, audio_out_d;
   logic                          out_valid_q, out_valid_d;
   logic [7:0]                    overrun_q, overrun_d;
   logic                          iv_prev_q, iv_prev_d;

   logic                          accept;
   logic signed [DATA_W-1:0]      band_sel;
   logic [GAIN_W-1:0]             gain_sel;
   logic signed [PROD_W-1:0]      a_ext, b_ext, prod;
   logic signed [ACC_W-1:0]       rnd_sum, rnd;
   logic [DATA_W-1:0]             sat_val;

   // Operand mux feeding the single shared multiplier
   always_comb begin
      band_sel = '0;
      gain_sel = '0;
      for (int k = 0; k < NUM_BANDS; k++) begin
         if (idx_q == IDX_W'(k)) begin
            band_sel = band_sh_q[k*DATA_W +: DATA_W];
            gain_sel = gain_sh_q[k*GAIN_W +: GAIN_W];
         end
      end
      a_ext = PROD_W'(band_sel);
      b_ext = {{(DATA_W+1){1'b0}}, gain_sel};
      prod  = a_ext * b_ext;
   end

   // Round half toward +inf, then clamp to the output range
   always_comb begin
      rnd_sum = acc_q + RND_HALF;
      rnd     = rnd_sum >>> GAIN_FRAC;
      if (rnd > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
      else if (rnd < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
      else                    sat_val = rnd[DATA_W-1:0];
   end

   assign accept = in_valid & ~iv_prev_q;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      band_sh_d   = band_sh_q;
      gain_sh_d   = gain_sh_q;
      audio_out_d = audio_out_q;
      out_valid_d = 1'b0;
      overrun_d   = overrun_q;
      iv_prev_d   = in_valid;
      case (state_q)
         IDLE: if (accept) begin
            band_sh_d = band_data;
            gain_sh_d = gain_bus;
            acc_d     = '0;
            idx_d     = '0;
            state_d   = MAC;
         end
         MAC: begin
            acc_d = acc_q + ACC_W'(prod);
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NUM_BANDS - 1)) state_d = SAT;
         end
         SAT: begin
            audio_out_d = sat_val;
            out_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A sample arriving while busy (including the SAT edge) is dropped
      if (accept && state_q != IDLE && overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         idx_q       <= '0;
         band_sh_q   <= '0;
         gain_sh_q   <= '0;
         audio_out_q <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= '0;
         iv_prev_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         band_sh_q   <= band_sh_d;
         gain_sh_q   <= gain_sh_d;
         audio_out_q <= audio_out_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
         iv_prev_q   <= iv_prev_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign busy        = ~in_ready;
   assign audio_out   = audio_out_q;
   assign out_valid   = out_valid_q;
   assign overrun_cnt = overrun_q;
endmodule

// File: tb/tb_eq_band_mac_scheduler.sv
// Directed bench for eq_band_mac_scheduler: hand-computed results, latency, handshake, overrun, reset.
module tb_eq_band_mac_scheduler;
   localparam int NB = 10;
   localparam int DW = 24;
   localparam int GW = 13;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic [NB*DW-1:0] band_data = '0;
   logic [NB*GW-1:0] gain_bus = '0;
   logic             in_ready, busy, out_valid;
   logic [DW-1:0]    audio_out;
   logic [7:0]       overrun_cnt;

   int errs = 0;
   int checks = 0;

   logic [DW-1:0] res;
   int lat, nv, rlo;

   eq_band_mac_scheduler dut (
      .clk(clk), .rst_n(rst_n), .band_data(band_data), .gain_bus(gain_bus),
      .in_valid(in_valid), .in_ready(in_ready), .busy(busy), .audio_out(audio_out),
      .out_valid(out_valid), .overrun_cnt(overrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic set_all(input logic [DW-1:0] b, input logic [GW-1:0] g);
      for (int k = 0; k < NB; k++) begin
         band_data[k*DW +: DW] = b;
         gain_bus[k*GW +: GW]  = g;
      end
   endtask

   // Starts a sample at the current negedge; c counts negedges after the accept drive.
   task automatic run_sample(input int hold, input int re_cyc, input int chg_cyc,
                             input logic [GW-1:0] chg_g, output logic [DW-1:0] r,
                             output int l, output int n, output int rl);
      r = '0; l = -1; n = 0; rl = 0;
      in_valid = 1'b1;
      for (int c = 1; c <= 26; c++) begin
         @(negedge clk);
         if (out_valid) begin
            if (n == 0) begin
               l = c - 1;
               r = audio_out;
            end
            n++;
         end
         if (!in_ready && n == 0) rl++;
         in_valid = (c < hold) || (c == re_cyc);
         if (c == chg_cyc)
            for (int k = 0; k < NB; k++) gain_bus[k*GW +: GW] = chg_g;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (audio_out !== 24'd0) begin errs++; $display("FAIL reset_audio_out: got %h want 0", audio_out); end
      checks++; if (overrun_cnt !== 8'd0) begin errs++; $display("FAIL reset_overrun: got %0d want 0", overrun_cnt); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_unity();
      set_all(24'd1000, 13'd512);
      run_sample(1, 0, 0, '0, res, lat, nv, rlo);
      checks++; if (res !== 24'd10000) begin errs++; $display("FAIL unity_result: got %0d want 10000", res); end
      checks++; if (lat !== 11) begin errs++; $display("FAIL unity_latency: got %0d want 11", lat); end
      checks++; if (nv !== 1) begin errs++; $display("FAIL unity_out_count: got %0d want 1", nv); end
      checks++; if (rlo !== 11) begin errs++; $display("FAIL unity_ready_low: got %0d want 11", rlo); end
   endtask

   task automatic test_saturation();
      set_all(24'h7FFFFF, 13'd8191);
      run_sample(1, 0, 0, '0, res, lat, nv, rlo);
      checks++; if (res !== 24'h7FFFFF) begin errs++; $display("FAIL sat_pos: got %h want 7fffff", res); end
      set_all(24'h800000, 13'd8191);
      run_sample(1, 0, 0, '0, res, lat, nv, rlo);
      checks++; if (res !== 24'h800000) begin errs++; $display("FAIL sat_neg: got %h want 800000", res); end
   endtask

   task automatic test_rounding();
      set_all('0, '0);
      band_data[DW-1:0] = 24'd3; gain_bus[GW-1:0] = 13'd256;
      run_sample(1, 0, 0, '0, res, lat, nv, rlo);
      checks++; if (res !== 24'd2) begin errs++; $display("FAIL round_pos_half: got %h want 000002", res); end
      band_data[DW-1:0] = 24'hFFFFFD;
      run_sample(1, 0, 0, '0, res, lat, nv, rlo);
      checks++; if (res !== 24'hFFFFFF) begin errs++; $display("FAIL round_neg_half: got %h want ffffff", res); end
      band_data[DW-1:0] = 24'd1; gain_bus[GW-1:0] = 13'd255;
      run_sample(1, 0, 0, '0, res, lat, nv, rlo);
      checks++; if (res !== 24'd0) begin errs++; $display("FAIL round_below_half: got %h want 000000", res); end
   endtask

   task automatic test_gain_hold();
      set_all(24'd1000, 13'd512);
      run_sample(1, 0, 5, 13'd1024, res, lat, nv, rlo);
      checks++; if (res !== 24'd10000) begin errs++; $display("FAIL gain_hold_old: got %0d want 10000", res); end
      run_sample(1, 0, 0, '0, res, lat, nv, rlo);
      checks++; if (res !== 24'd20000) begin errs++; $display("FAIL gain_hold_new: got %0d want 20000", res); end
   endtask

   task automatic test_handshake();
      set_all(24'd1000, 13'd512);
      run_sample(5, 0, 0, '0, res, lat, nv, rlo);
      checks++; if (nv !== 1) begin errs++; $display("FAIL level_hold_outs: got %0d want 1", nv); end
      checks++; if (overrun_cnt !== 8'd0) begin errs++; $display("FAIL level_hold_overrun: got %0d want 0", overrun_cnt); end
      checks++; if (res !== 24'd10000) begin errs++; $display("FAIL level_hold_result: got %0d want 10000", res); end
      run_sample(1, 6, 0, '0, res, lat, nv, rlo);
      checks++; if (nv !== 1) begin errs++; $display("FAIL overrun_mac_outs: got %0d want 1", nv); end
      checks++; if (overrun_cnt !== 8'd1) begin errs++; $display("FAIL overrun_mac_cnt: got %0d want 1", overrun_cnt); end
   endtask

   task automatic test_back_to_back();
      set_all(24'd1000, 13'd512);
      run_sample(1, 11, 0, '0, res, lat, nv, rlo);
      checks++; if (overrun_cnt !== 8'd2) begin errs++; $display("FAIL sat_edge_overrun: got %0d want 2", overrun_cnt); end
      checks++; if (nv !== 1) begin errs++; $display("FAIL sat_edge_outs: got %0d want 1", nv); end
      run_sample(1, 12, 0, '0, res, lat, nv, rlo);
      checks++; if (nv !== 2) begin errs++; $display("FAIL b2b_outs: got %0d want 2", nv); end
      checks++; if (overrun_cnt !== 8'd2) begin errs++; $display("FAIL b2b_overrun: got %0d want 2", overrun_cnt); end
   endtask

   task automatic test_overrun_saturate();
      int dbl = 0;
      logic prev = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (prev && out_valid) dbl++;
         prev = out_valid;
         in_valid = ~in_valid;
      end
      in_valid = 1'b0;
      repeat (20) @(negedge clk);
      checks++; if (overrun_cnt !== 8'd255) begin errs++; $display("FAIL overrun_saturate: got %0d want 255", overrun_cnt); end
      checks++; if (dbl !== 0) begin errs++; $display("FAIL out_valid_double: got %0d want 0", dbl); end
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      set_all(24'd1000, 13'd512);
      in_valid = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL midrst_idle: got %b want 1", in_ready); end
      checks++; if (audio_out !== 24'd0) begin errs++; $display("FAIL midrst_audio: got %h want 0", audio_out); end
      checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
      checks++; if (overrun_cnt !== 8'd0) begin errs++; $display("FAIL midrst_overrun: got %0d want 0", overrun_cnt); end
      rst_n = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (out_valid || !in_ready) bad++;
      end
      checks++; if (bad !== 0) begin errs++; $display("FAIL held_level_accepted: got %0d busy/valid cycles want 0", bad); end
      in_valid = 1'b0;
      @(negedge clk);
      run_sample(1, 0, 0, '0, res, lat, nv, rlo);
      checks++; if (res !== 24'd10000) begin errs++; $display("FAIL post_reset_result: got %0d want 10000", res); end
      checks++; if (nv !== 1) begin errs++; $display("FAIL post_reset_outs: got %0d want 1", nv); end
   endtask

   initial begin
      test_reset();
      test_unity();
      test_saturation();
      test_rounding();
      test_gain_hold();
      test_handshake();
      test_back_to_back();
      test_overrun_saturate();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
